quad_gen: RTL
=============

QUAD_GEN -- requirements
Module: quad_gen

Interface
REQ-001 SHALL have parameter STEP_W, default 10, width of step count and position.
REQ-002 SHALL have parameter PERIOD_W, default 16, width of step period.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port a_reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_dir  input  1  1 = FORWARD, 0 = BACK.
REQ-008 SHALL have port cmd_steps  input  STEP_W  number of quadrature steps to emit.
REQ-009 SHALL have port period  input  PERIOD_W  clocks per step; 0 treated as 1; sampled at acceptance.
REQ-010 SHALL have port abort  input  1  synchronous stop request.
REQ-011 SHALL have port encoder_a  output  1  phase A, registered.
REQ-012 SHALL have port encoder_b  output  1  phase B, registered.
REQ-013 SHALL have port position  output  STEP_W  signed-free running count of emitted steps, mod 2^STEP_W.
REQ-014 SHALL have port busy  output  1  high while in RUN.
REQ-015 SHALL have port done  output  1  one-cycle pulse on command completion.

Function
REQ-016 SHALL implement FSM states IDLE and RUN; cmd_ready = (state==IDLE) and not abort.
REQ-017 SHALL accept a command on the rising edge where cmd_valid and cmd_ready are both high, latching cmd_dir, cmd_steps, and max(period,1).
REQ-018 SHALL, on acceptance with cmd_steps = 0, stay in IDLE, leave outputs unchanged, and pulse done on the following cycle.
REQ-019 SHALL, on acceptance with cmd_steps > 0, enter RUN, load remaining = cmd_steps, and set timer = P-1.
REQ-020 SHALL, in RUN, decrement timer each cycle; when timer = 0, advance one phase, reload timer = P-1, and decrement remaining.
REQ-021 SHALL present the first phase change at the outputs exactly P clocks after the acceptance edge, with subsequent changes every P clocks.
REQ-022 SHALL follow the FORWARD sequence {A,B}: 00->10->11->01->00.
REQ-023 SHALL follow the BACK sequence {A,B}: 00->01->11->10->00.
REQ-024 SHALL change exactly one of A, B per step and never change both in the same cycle.
REQ-025 SHALL increment position on each FORWARD step and decrement it on each BACK step, wrapping modulo 2^STEP_W (1023+1=0, 0-1=1023).
REQ-026 SHALL, on the step where remaining reaches 0, return to IDLE and assert done for one cycle in the same cycle the final phase appears.
REQ-027 SHALL treat abort in RUN as follows: return to IDLE next edge, hold phase and position, drop remaining, and not assert done.
REQ-028 SHALL ignore abort in IDLE, apart from its effect of blocking cmd_ready.
REQ-029 SHALL hold the phase between commands; a new command SHALL continue from the current phase, and direction reversal SHALL be legal.
REQ-030 SHALL make cmd_ready low throughout RUN; cmd_valid in RUN SHALL be held off, not dropped.

Reset
REQ-031 SHALL, on a_reset low, asynchronously set state=IDLE, encoder_a=0, encoder_b=0, position=0, busy=0, done=0, timer=0, remaining=0.
REQ-032 SHALL abandon a command interrupted by reset mid-RUN without a done pulse, and resume normal operation on the first edge after release.

Structure
REQ-033 SHALL place the state enum (IDLE, RUN), the direction enum (FORWARD, BACK), and the 2-bit phase typedef in shared package quad_pkg.
REQ-034 SHALL use one sub-module, quad_phase_step: combinational next-phase computed from current phase and direction.

Verification
REQ-035 SHALL cover: reset, then FORWARD with 4 steps and period 3 -> AB 10,11,01,00 at +3,+6,+9,+12 cycles; position=4; done at +12.
REQ-036 SHALL cover: BACK with 2 steps and period 1 from position 0 -> AB 01,11 on consecutive cycles; position=1022; done at second step.
REQ-037 SHALL cover: cmd_steps=0 -> no AB change; done one cycle after acceptance; cmd_ready stays high.
REQ-038 SHALL cover: FORWARD with 10 steps and period 5, abort after 3 steps -> AB frozen at 01; position=3; no done; cmd_ready high next cycle.
REQ-039 SHALL cover: a_reset pulsed mid-RUN -> AB=00, position=0, busy=0 immediately; no done.
REQ-040 SHALL cover: loopback into quadrature decoder over random commands -> decoder coordinate equals position two cycles after each step, with no decoder ERROR.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types for the quadrature pulse generator.
//   state_e : controller states (idle / running a command)
//   dir_e   : step direction as carried on cmd_dir (1 = forward, 0 = back)
//   phase_t : encoder phase packed as {A, B}
package quad_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  typedef enum logic {
    DirBack    = 1'b0,
    DirForward = 1'b1
  } dir_e;

  typedef logic [1:0] phase_t;

  localparam phase_t PhaseRest = 2'b00;

endpackage

// File: rtl/quad_phase_step.sv
// Combinational one-step advance of a quadrature phase.
//   phase_i : current phase {A, B}
//   dir_i   : direction of the step
//   phase_o : phase after one step; exactly one of A, B differs from phase_i
module quad_phase_step
  import quad_pkg::*;
(
  input  phase_t phase_i,
  input  dir_e   dir_i,
  output phase_t phase_o
);

  // Forward walks 00->10->11->01, i.e. {A,B} <= {~B, A}.
  // Back walks 00->01->11->10, i.e. {A,B} <= {B, ~A}.
  always_comb begin
    phase_o = phase_i;
    unique case (dir_i)
      DirForward: phase_o = {~phase_i[0], phase_i[1]};
      DirBack:    phase_o = {phase_i[0], ~phase_i[1]};
      default:    phase_o = phase_i;
    endcase
  end

endmodule

// File: rtl/quad_gen.sv
// Quadrature encoder pulse generator.
// Accepts a command (direction, step count, clocks-per-step) over a valid/ready
// handshake and emits that many quadrature steps on encoder_a/encoder_b, keeping
// a wrapping position count. abort stops a running command without done.
//   clock, a_reset        : rising-edge clock, async active-low reset
//   cmd_valid/cmd_ready   : command handshake (ready only when idle and no abort)
//   cmd_dir/cmd_steps     : direction (1 = forward) and step count
//   period                : clocks per step, 0 treated as 1, sampled at accept
//   abort                 : synchronous stop request
//   encoder_a/encoder_b   : registered quadrature phases
//   position              : steps emitted, +1 forward / -1 back, mod 2^STEP_W
//   busy, done            : running flag, one-cycle completion pulse
module quad_gen
  import quad_pkg::*;
#(
  parameter int unsigned STEP_W   = 10,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clock,
  input  logic                a_reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [STEP_W-1:0]   cmd_steps,
  input  logic [PERIOD_W-1:0] period,
  input  logic                abort,
  output logic                encoder_a,
  output logic                encoder_b,
  output logic [STEP_W-1:0]   position,
  output logic                busy,
  output logic                done
);

  state_e              state_q, state_d;
  dir_e                dir_q, dir_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [STEP_W-1:0]   remaining_q, remaining_d;
  phase_t              phase_q, phase_d;
  logic [STEP_W-1:0]   position_q, position_d;
  logic                done_q, done_d;

  logic                accept;
  logic                step_fire;
  logic                last_step;
  logic [PERIOD_W-1:0] period_eff;
  phase_t              phase_next;

  quad_phase_step u_phase_step (
    .phase_i (phase_q),
    .dir_i   (dir_q),
    .phase_o (phase_next)
  );

  always_comb begin
    accept     = cmd_valid && cmd_ready;
    period_eff = (period == '0) ? PERIOD_W'(1) : period;
    step_fire  = (state_q == StRun) && !abort && (timer_q == '0);
    last_step  = step_fire && (remaining_q == STEP_W'(1));
  end

  // State register.
  always_ff @(posedge clock or negedge a_reset) begin
    if (!a_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept && (cmd_steps != '0)) state_d = StRun;
      StRun:  if (abort || last_step) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    cmd_ready = (state_q == StIdle) && !abort;
    busy      = (state_q == StRun);
    encoder_a = phase_q[1];
    encoder_b = phase_q[0];
    position  = position_q;
    done      = done_q;
  end

  // Datapath next values.
  always_comb begin
    dir_d       = dir_q;
    period_d    = period_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    phase_d     = phase_q;
    position_d  = position_q;
    done_d      = 1'b0;

    if (state_q == StIdle) begin
      if (accept) begin
        dir_d    = dir_e'(cmd_dir);
        period_d = period_eff;
        if (cmd_steps == '0) begin
          // Empty command: complete immediately, outputs untouched.
          done_d = 1'b1;
        end else begin
          remaining_d = cmd_steps;
          timer_d     = period_eff - PERIOD_W'(1);
        end
      end
    end else if (abort) begin
      // Phase and position are held; the rest of the command is dropped.
      remaining_d = '0;
      timer_d     = '0;
    end else if (step_fire) begin
      phase_d     = phase_next;
      position_d  = (dir_q == DirForward) ? position_q + STEP_W'(1)
                                          : position_q - STEP_W'(1);
      remaining_d = remaining_q - STEP_W'(1);
      timer_d     = last_step ? '0 : period_q - PERIOD_W'(1);
      done_d      = last_step;
    end else begin
      timer_d = timer_q - PERIOD_W'(1);
    end
  end

  always_ff @(posedge clock or negedge a_reset) begin
    if (!a_reset) begin
      dir_q       <= DirForward;
      period_q    <= PERIOD_W'(1);
      timer_q     <= '0;
      remaining_q <= '0;
      phase_q     <= PhaseRest;
      position_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      dir_q       <= dir_d;
      period_q    <= period_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      phase_q     <= phase_d;
      position_q  <= position_d;
      done_q      <= done_d;
    end
  end

endmodule
